// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: instruction field positions, data width and fetch FSM states.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int OPC_LSB = 0;
  localparam int F3_LSB  = 12;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    WAIT_STALE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head data is a combinational read at rd_ptr.
// Storage resets to zero so the head shows a zeroed entry out of reset.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot being written, so push-while-full is accepted only alongside a pop.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the PC, issues one outstanding icache read at a time and queues
// returned words with their PC; a redirect flushes the queue and drops any in-flight response.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            icache_rd_en,
  output logic [XLEN-1:0] icache_addr,
  input  logic            icache_dout_valid,
  input  logic [XLEN-1:0] icache_dout,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            ifq_rd_en,
  output logic            ifq_empty,
  output logic [XLEN-1:0] ifq_instr,
  output logic [XLEN-1:0] ifq_pc,
  output logic [XLEN-1:0] ifq_pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [1:0]      mod
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     req_pc;
  logic                issue;
  logic                push;
  logic                fifo_full;
  logic [AW:0]         fifo_count;
  logic [2*XLEN-1:0]   head;

  // Held low during reset so the request port is quiet while rst_n is asserted.
  assign issue = rst_n && (state == IDLE) && (fifo_count < DEPTH_C) && !jump_valid;
  assign push  = (state == WAIT) && icache_dout_valid && !jump_valid && !fifo_full;

  assign icache_rd_en = issue;
  assign icache_addr  = issue ? pc : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        if (jump_valid) state_nxt = icache_dout_valid ? IDLE : WAIT_STALE;
        else if (icache_dout_valid) state_nxt = IDLE;
      end
      WAIT_STALE: begin
        if (icache_dout_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (jump_valid) begin
        pc <= jump_addr;
      end else if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (jump_valid),
    .wr_en   (push),
    .wr_data ({icache_dout, req_pc}),
    .rd_en   (ifq_rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (ifq_empty),
    .count   (fifo_count)
  );

  assign ifq_instr    = head[2*XLEN-1:XLEN];
  assign ifq_pc       = head[XLEN-1:0];
  assign ifq_pc_plus4 = ifq_pc + 32'd4;
  assign opcode       = ifq_instr[OPC_LSB +: 7];
  assign funct3       = ifq_instr[F3_LSB +: 3];
  assign mod          = {ifq_instr[30], ifq_instr[25]};

endmodule
